// File: rtl/pwm_timer_bank.sv
// pwm_timer_bank: shared-timebase PWM / interval / one-shot timer bank.
//
// A single prescaler and period counter serve CH output channels. The period
// and the per-channel compare values are double-buffered. An update strobe loads
// the shadow copies. The active copies take the shadow values at each counter
// wrap, or on every cycle while the bank is disabled. This way a running period
// is never disturbed by a mid-period update.
//
// Ports:
//   clk            single clock, rising-edge active
//   reset          asynchronous active-high reset
//   enable         run control; low stops/clears the counter, outputs idle
//   prescale       counter advances once per prescale+1 enabled cycles
//   max_count      requested period P (counter runs 0..P)
//   compare        per-channel compare C, channel i in [i*WIDTH +: WIDTH]
//   update         one-cycle strobe capturing max_count/compare into shadow
//   mode           per channel: 00 off, 01 interval, 10 PWM, 11 one-shot
//   invert         per-channel output polarity
//   signal         registered channel outputs
//   period_tick    registered one-cycle pulse per counter wrap
//   o_dbg_os_state one-shot FSM state per channel (2 bits each)
module pwm_timer_bank #(
    parameter int WIDTH   = 16,
    parameter int CH      = 4,
    parameter int PRESC_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic [WIDTH-1:0]      max_count,
    input  logic [CH*WIDTH-1:0]   compare,
    input  logic                  update,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH-1:0]         invert,
    output logic [CH-1:0]         signal,
    output logic                  period_tick,
    output logic [2*CH-1:0]       o_dbg_os_state
);

    typedef enum logic [1:0] {
        OS_IDLE = 2'd0,
        OS_PEND = 2'd1,
        OS_ACT  = 2'd2,
        OS_DONE = 2'd3
    } os_state_t;

    logic [PRESC_W-1:0] r_psc;
    logic [WIDTH-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_p_sh;
    logic [WIDTH-1:0]   r_p_act;
    logic [WIDTH-1:0]   r_c_sh  [CH];
    logic [WIDTH-1:0]   r_c_act [CH];
    os_state_t          r_os_state [CH];
    logic [CH-1:0]      r_signal;
    logic               r_tick;

    logic               w_adv;
    logic               w_wrap;
    logic [CH-1:0]      w_raw;

    assign w_adv  = enable && (r_psc == prescale);
    assign w_wrap = w_adv && (r_cnt == r_p_act);

    // Shared prescaler and period counter. Disabling clears both so a re-enable
    // always starts a fresh, aligned period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_psc  <= '0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!enable) begin
            r_psc  <= '0;
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (w_adv) begin
                r_psc <= '0;
            end else begin
                r_psc <= r_psc + 1'b1;
            end
            if (w_wrap) begin
                r_cnt <= '0;
            end else if (w_adv) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Shadow/active double buffer. Nonblocking semantics mean an update that
    // lands on a wrap cycle moves the *old* shadow into active. The new value
    // therefore waits for the following wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p_sh  <= '0;
            r_p_act <= '0;
            for (int i = 0; i < CH; i++) begin
                r_c_sh[i]  <= '0;
                r_c_act[i] <= '0;
            end
        end else begin
            if (update) begin
                r_p_sh <= max_count;
                for (int i = 0; i < CH; i++) begin
                    r_c_sh[i] <= compare[i*WIDTH +: WIDTH];
                end
            end
            if (w_wrap || !enable) begin
                r_p_act <= r_p_sh;
                for (int i = 0; i < CH; i++) begin
                    r_c_act[i] <= r_c_sh[i];
                end
            end
        end
    end

    // One-shot FSMs. Leaving mode 11 re-arms the channel through IDLE. With
    // enable low no wrap can occur, so PEND/ACT simply hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                r_os_state[i] <= OS_IDLE;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (mode[2*i +: 2] != 2'b11) begin
                    r_os_state[i] <= OS_IDLE;
                end else begin
                    case (r_os_state[i])
                        OS_IDLE: r_os_state[i] <= OS_PEND;
                        OS_PEND: if (w_wrap) r_os_state[i] <= OS_ACT;
                        OS_ACT:  if (w_wrap) r_os_state[i] <= OS_DONE;
                        default: r_os_state[i] <= OS_DONE;
                    endcase
                end
            end
        end
    end

    // Raw per-channel waveform from the current counter value. ACT spans exactly
    // one full period (entered and left on a wrap), so a one-shot emits one
    // C-count pulse.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < CH; i++) begin
            case (mode[2*i +: 2])
                2'b01:   w_raw[i] = w_wrap;
                2'b10:   w_raw[i] = (r_cnt < r_c_act[i]);
                2'b11:   w_raw[i] = (r_os_state[i] == OS_ACT) && (r_cnt < r_c_act[i]);
                default: w_raw[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_signal <= '0;
        end else if (!enable) begin
            r_signal <= invert;
        end else begin
            r_signal <= w_raw ^ invert;
        end
    end

    assign signal      = r_signal;
    assign period_tick = r_tick;

    for (genvar g = 0; g < CH; g++) begin : g_dbg
        assign o_dbg_os_state[2*g +: 2] = r_os_state[g];
    end

endmodule

// File: doc/pwm_timer_bank.md
PWM_TIMER_BANK -- requirements
Module: pwm_timer_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter/period/compare width in bits.
REQ-002 SHALL have parameter CH, default 4, number of output channels.
REQ-003 SHALL have parameter PRESC_W, default 8, prescaler width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  run control; low = counter stopped and outputs at idle level.
REQ-007 SHALL have port prescale  input  PRESC_W  clock divider; counter advances once per prescale+1 cycles.
REQ-008 SHALL have port max_count  input  WIDTH  requested period value P; the counter runs 0..P.
REQ-009 SHALL have port compare  input  CH*WIDTH  requested compare value C per channel; channel i uses bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port update  input  1  one-cycle strobe that captures max_count and compare into shadow registers.
REQ-011 SHALL have port mode  input  2*CH  per-channel mode: 00 off, 01 interval, 10 PWM, 11 one-shot.
REQ-012 SHALL have port invert  input  CH  per-channel output polarity.
REQ-013 SHALL have port signal  output  CH  registered channel outputs.
REQ-014 SHALL have port period_tick  output  1  registered one-cycle pulse per counter wrap.

Function
REQ-015 SHALL keep one shared prescaler psc and one shared counter cnt; adv = enable && psc==prescale; on adv psc<=0, otherwise psc<=psc+1.
REQ-016 SHALL define wrap = adv && cnt==P_act; on wrap cnt<=0; on adv without wrap cnt<=cnt+1; otherwise cnt holds.
REQ-017 SHALL load shadow P_sh and C_sh[i] from the inputs on update.
REQ-018 SHALL copy shadow into active P_act and C_act[i] on wrap, or on every cycle while enable=0.
REQ-019 SHALL, when update and wrap occur in the same cycle, load the old shadow into active; the new values take effect at the following wrap.
REQ-020 SHALL register period_tick <= wrap, giving a 1-cycle latency.
REQ-021 SHALL compute each signal[i] as a registered raw[i]^invert[i], 1-cycle latency from the cnt value.
REQ-022 SHALL compute raw per mode as follows: off = 0; interval = wrap; PWM = (cnt < C_act[i]).
REQ-023 SHALL, in PWM mode, give duty C/(P+1); C=0 gives constant 0; C>P gives constant 1 (no glitch at wrap).
REQ-024 SHALL give each channel a one-shot FSM {IDLE, PEND, ACT, DONE}:
 - any mode value other than 11 -> IDLE;
 - IDLE with mode=11 -> PEND;
 - PEND on wrap -> ACT;
 - ACT on wrap -> DONE;
 - DONE holds until mode leaves 11.
REQ-025 SHALL, in one-shot mode, give raw = (state==ACT && cnt < C_act[i]); one pulse of C counts in exactly one full period.
REQ-026 SHALL, on a mode change of one channel, affect only that channel; cnt is not restarted.
REQ-027 SHALL, with P_act=0, hold cnt at 0 and assert wrap on every adv.
REQ-028 SHALL, with prescale=0, assert adv every enabled cycle.
REQ-029 SHALL, while enable=0, clear psc and cnt to 0 and hold period_tick=0; signal[i] = invert[i]; FSMs in PEND/ACT hold their state.
REQ-030 SHALL wrap all arithmetic at WIDTH/PRESC_W bits; comparisons are unsigned.

Reset
REQ-031 SHALL, while reset=1, force psc, cnt, P_sh, P_act, all C_sh and C_act, signal and period_tick to 0, and every FSM to IDLE.
REQ-032 SHALL make signal equal invert on the first clock edge after reset deasserts, provided mode=off.
REQ-033 SHALL clear all state immediately on reset asserted mid-period, with no further outputs until new update/enable.

Verification
REQ-034 SHALL verify PWM: P=9, C0=3, prescale=0, mode0=10, update, enable -> signal[0] 3 cycles high of every 10; period_tick every 10 cycles.
REQ-035 SHALL verify the prescaler: prescale=1, P=4, mode1=01 -> signal[1] 1-cycle pulse every 10 cycles, coincident with period_tick.
REQ-036 SHALL verify shadow timing: C0 changed 3->7 with update mid-period -> current period keeps 3-high, next period 7-high; update on a wrap cycle -> change is delayed one further period.
REQ-037 SHALL verify boundaries: C=0 -> constant 0; C=12 with P=9 -> constant 1; invert=1 with C=0 -> constant 1; P=0 -> period_tick every enabled cycle.
REQ-038 SHALL verify one-shot: mode2=11 set mid-period with C=4, P=9 -> low for the rest of that period, exactly 4 high cycles in the next period, then low permanently; toggling mode2 to 00 and back to 11 re-arms the channel.
REQ-039 SHALL verify reset mid-operation: reset pulsed during a PWM high phase -> signal=0 and period_tick=0 asynchronously, and cnt restarts from 0 only after update and enable.
